// File: rtl/io_stream_checker_if.sv
// Monitor-side bundle for io_stream_checker: CPU bus taps plus run status.
// master drives the taps and start; slave is the checker itself.
interface io_stream_checker_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [15:0]      addr;
  logic [WIDTH-1:0] bus;
  logic             DI;
  logic             busy;
  logic             done;
  logic             pass;
  logic [15:0]      out_count;
  logic [15:0]      error_count;
  logic [3:0]       bad_port;
  logic [WIDTH-1:0] bad_value;
  logic [WIDTH-1:0] bad_expect;

  modport master (
    output start, addr, bus, DI,
    input  busy, done, pass,
    input  out_count, error_count,
    input  bad_port, bad_value, bad_expect
  );

  modport slave (
    input  start, addr, bus, DI,
    output busy, done, pass,
    output out_count, error_count,
    output bad_port, bad_value, bad_expect
  );
endinterface

// File: rtl/io_stream_checker.sv
// Checks CPU I/O writes to NPORTS ports against per-port arithmetic
// sequences over a bounded run window and reports a pass/fail verdict.
module io_stream_checker #(
  parameter int WIDTH         = 16,
  parameter int NPORTS        = 1,
  parameter int ADDR_BASE     = 0,
  parameter int START         = 0,
  parameter int STEP          = 1,
  parameter int EXPECT_COUNT  = 24,
  parameter int MAX_CYCLES    = 2000,
  parameter int STOP_ON_ERROR = 0
) (
  input logic               clk,
  input logic               reset,
  io_stream_checker_if.slave io
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int NE = 1 << PW;

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [15:0]      EXP_V   = 16'(EXPECT_COUNT);
  localparam logic [31:0]      MAX_V   = 32'(MAX_CYCLES);
  localparam logic [16:0]      BASE_V  = 17'(ADDR_BASE);
  localparam logic [16:0]      NP_V    = 17'(NPORTS);
  localparam logic             STOP_V  = (STOP_ON_ERROR != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [WIDTH-1:0] exp_q [NE];
  logic [15:0]      out_q, out_d;
  logic [15:0]      err_q, err_d;
  logic             pass_q;
  logic [3:0]       bad_port_q;
  logic [WIDTH-1:0] bad_value_q;
  logic [WIDTH-1:0] bad_expect_q;

  logic [16:0]      off;
  logic [PW-1:0]    port;
  logic [WIDTH-1:0] exp_cur;
  logic             hit, mism, last, clr, run;

  // 17-bit offset: addresses below the base wrap to huge values and miss
  assign off     = {1'b0, io.addr} - BASE_V;
  assign port    = off[PW-1:0];
  assign hit     = io.DI && (off < NP_V);
  assign exp_cur = exp_q[port];
  assign mism    = hit && (io.bus != exp_cur);
  assign run     = (state_q == RUN);
  assign cyc_d   = cyc_q + 32'd1;
  assign last    = (cyc_d == MAX_V);
  assign clr     = !run && io.start;

  assign out_d = (hit && out_q != 16'hFFFF)
               ? out_q + 16'd1 : out_q;
  assign err_d = (mism && err_q != 16'hFFFF)
               ? err_q + 16'd1 : err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (io.start) state_d = RUN;
      RUN:  if (last || (STOP_V && mism)) state_d = DONE;
      DONE: if (io.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q        <= '0;
      out_q        <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      bad_port_q   <= '0;
      bad_value_q  <= '0;
      bad_expect_q <= '0;
      for (int i = 0; i < NE; i++) exp_q[i] <= START_V;
    end else if (clr) begin
      cyc_q        <= '0;
      out_q        <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      bad_port_q   <= '0;
      bad_value_q  <= '0;
      bad_expect_q <= '0;
      for (int i = 0; i < NE; i++) exp_q[i] <= START_V;
    end else if (run) begin
      cyc_q <= cyc_d;
      out_q <= out_d;
      err_q <= err_d;
      // sequence advances even past a bad write, so one glitch costs one error
      if (hit) exp_q[port] <= exp_cur + STEP_V;
      if (mism && err_q == 16'd0) begin
        bad_port_q   <= off[3:0];
        bad_value_q  <= io.bus;
        bad_expect_q <= exp_cur;
      end
      if (state_d == DONE)
        pass_q <= (err_d == 16'd0) && (out_d == EXP_V);
    end
  end

  assign io.busy        = run;
  assign io.done        = (state_q == DONE);
  assign io.pass        = pass_q;
  assign io.out_count   = out_q;
  assign io.error_count = err_q;
  assign io.bad_port    = bad_port_q;
  assign io.bad_value   = bad_value_q;
  assign io.bad_expect  = bad_expect_q;

endmodule

// File: doc/io_stream_checker.md
Name: io_stream_checker

Overview:
- Synthesizable self-checking monitor for CPU output traffic, usable in simulation benches and on the FPGA.
- Watches the CPU address bus, data bus and DI strobe for writes to NPORTS consecutive I/O addresses starting at ADDR_BASE.
- Each port is checked against its own expected arithmetic sequence (START, START+STEP, ...). The block counts writes and mismatches over a bounded run window, then reports a pass/fail verdict.

Parameters:
- WIDTH, 16, data bus width in bits.
- NPORTS, 1, number of monitored consecutive I/O addresses (1..16).
- ADDR_BASE, 0, address of port 0.
- START, 0, first expected value on every port.
- STEP, 1, per-port increment between expected values, modulo 2^WIDTH.
- EXPECT_COUNT, 24, required total number of writes across all ports for a pass.
- MAX_CYCLES, 2000, length of the run window in clk cycles.
- STOP_ON_ERROR, 0, if 1 the run ends on the cycle after the first mismatch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a run.
- addr  input  16  CPU address bus.
- bus  input  WIDTH  CPU data bus.
- DI  input  1  CPU device-input (I/O write) strobe.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  verdict; valid only while done is high.
- out_count  output  16  total matched plus mismatched writes; saturates at 16'hFFFF.
- error_count  output  16  mismatch count; saturates at 16'hFFFF.
- bad_port  output  4  port index of the first mismatch.
- bad_value  output  WIDTH  value observed at the first mismatch.
- bad_expect  output  WIDTH  value expected at the first mismatch.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - state = IDLE; busy = done = pass = 0.
  - All counters, bad_* outputs and the cycle counter cleared to 0.
  - Every per-port expected register set to START.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 moves to RUN next edge and clears counters, bad_*, cycle counter and expected registers (to START).
  - Monitor inputs are ignored.
- RUN:
  - cycle counter increments every edge.
  - Write hit = DI && ADDR_BASE <= addr < ADDR_BASE+NPORTS; port index p = addr - ADDR_BASE. Inputs are sampled on the rising edge.
  - On a hit:
    - out_count increments.
    - If bus != expect[p], error_count increments.
    - If this is the first mismatch of the run (error_count was 0), capture bad_port/bad_value/bad_expect.
    - expect[p] advances by STEP (wraps mod 2^WIDTH), whether the write matched or not.
  - Writes to addresses outside the window, or with DI = 0, have no effect.
  - start is ignored.
- RUN exit to DONE: on the edge where the cycle counter reaches MAX_CYCLES. A write sampled on that same edge is counted.
- STOP_ON_ERROR = 1: a mismatch also moves the block to DONE on that same edge, and the mismatch is counted.
- DONE:
  - pass = (error_count == 0) && (out_count == EXPECT_COUNT); pass is registered on entry to DONE.
  - All counters hold.
  - start = 1 begins a fresh run: clears as in IDLE and goes to RUN.
- Latency: out_count, error_count and bad_* reflect a write one edge after it is sampled.
- Saturation: the counters never wrap. A saturated out_count can only pass if EXPECT_COUNT = 16'hFFFF.
- Ports are fully independent: interleaved writes to different ports each follow their own sequence.

Test Plan:
1. Defaults; drive DI with addr = 0 and bus = 0..23 on 24 scattered cycles within 2000 -> done at cycle 2000, pass = 1, out_count = 24, error_count = 0.
2. Defaults; value sequence 0,1,2,7,4..23 -> pass = 0, error_count = 1, bad_port = 0, bad_value = 7, bad_expect = 3. The value 4 that follows is accepted, because expect advanced past the bad write.
3. NPORTS = 4, ADDR_BASE = 16'h0100, STEP = 2; interleave writes to 0x100..0x103 with 0,2,4 on each port (12 writes), EXPECT_COUNT = 12; add stray writes to 0x0104 and 0x00FF -> pass = 1, out_count = 12.
4. STOP_ON_ERROR = 1; mismatch at cycle 50 -> done one edge later, error_count = 1, pass = 0, no further writes counted.
5. Assert reset at cycle 700 mid-run with out_count = 10 -> busy = 0, out_count = 0 immediately (without waiting for a clock edge). A new start then runs a clean 2000-cycle window.
6. WIDTH = 8, START = 8'hFE, STEP = 1; values FE, FF, 00, 01 -> no errors (wrap-around). Write on the MAX_CYCLES edge is counted; a write one cycle later is not.
